wb_master_bridge: RTL and testbench
===================================

Name: wb_master_bridge

Overview:
Parametrised Wishbone classic master bridging the core's load/store transaction interface to the system bus. Latches the request and enforces natural alignment. Drives byte-lane selects from the address offset. Replicates write data across lanes and sign- or zero-extends read data. Terminates cycles on ack, bus error or timeout and reports a status code. Sits between the core LSU and the Wishbone interconnect, one instance per master port.

Parameters:
DATA_WIDTH, 32, transaction and Wishbone data width; legal values 32 or 64.
ADDR_WIDTH, 32, transaction and Wishbone address width.
SEL_WIDTH, DATA_WIDTH/8, byte-select width (derived, do not override).
TIMEOUT_CYCLES, 255, max BUS cycles without ack/err before abort; 0 disables timeout.

Ports:
clk_i  in  1  clock
rst_i  in  1  reset, asynchronous, active-high
transaction_addr_i  in  ADDR_WIDTH  byte address
transaction_data_i  in  DATA_WIDTH  write data, right-aligned
transaction_size_i  in  2  0 byte, 1 half, 2 word, 3 dword
transaction_unsigned_i  in  1  1 = zero-extend read, 0 = sign-extend
transaction_we_i  in  1  1 = write
transaction_start_i  in  1  request, sampled in IDLE only
transaction_clear_ready_i  in  1  acknowledge result, DONE -> IDLE
transaction_data_o  out  DATA_WIDTH  extended read data
transaction_ready_o  out  1  result valid (DONE)
transaction_error_o  out  2  0 ok, 1 misaligned/illegal size, 2 bus error, 3 timeout
wb_ack_i  in  1  Wishbone ack
wb_err_i  in  1  Wishbone error
wb_data_i  in  DATA_WIDTH  Wishbone read data
wb_addr_o  out  ADDR_WIDTH  bus-word-aligned address (low log2(SEL_WIDTH) bits zero)
wb_data_o  out  DATA_WIDTH  lane-replicated write data
wb_we_o  out  1  write enable
wb_sel_o  out  SEL_WIDTH  byte lanes
wb_stb_o  out  1  strobe
wb_cyc_o  out  1  cycle

Behaviour:
- Reset (async, any state including mid-cycle): state IDLE; stb, cyc, we, sel = 0; wb_addr_o, wb_data_o = 0; ready = 0; error = 0; transaction_data_o = 32'hC0017A1E replicated DATA_WIDTH/32 times; timeout counter = 0.
- States: IDLE, BUS, DONE.
- IDLE, start = 1:
  - Latch addr, data, size, unsigned, we.
  - Illegal request: size 3 with DATA_WIDTH = 32, or offset not a multiple of 2^size. Go to DONE, error = 1, no bus activity, transaction_data_o unchanged.
  - Legal request: go to BUS. stb, cyc high the next cycle. wb_sel_o = ((1 << 2^size) - 1) << offset, offset = addr mod SEL_WIDTH. wb_we_o = we.
  - Write data: low 2^size bytes replicated across all lanes. Example: byte 0xAB on 32-bit bus -> 0xABABABAB.
- BUS:
  - Outputs held stable. Counter increments each cycle.
  - err = 1 -> DONE, error = 2. Err wins over a simultaneous ack.
  - Else ack = 1 -> DONE, error = 0. On a read, transaction_data_o = (wb_data_i >> 8*offset), truncated to 2^size bytes, sign- or zero-extended to DATA_WIDTH. On a write, transaction_data_o is unchanged.
  - Else, TIMEOUT_CYCLES != 0 and counter == TIMEOUT_CYCLES - 1 -> DONE, error = 3.
  - Every exit from BUS deasserts stb, cyc, we and sel in the same edge and clears the counter.
- DONE:
  - ready = 1; error held.
  - clear_ready = 1 -> IDLE; ready = 0 the next cycle; error holds until the next start.
  - start is ignored in DONE and BUS, including when it coincides with clear_ready.
- Latency: start at edge N -> stb at N+1. Ack at edge M -> ready = 1 and stb = 0 at M+1. Minimum start-to-ready is 2 cycles (zero-wait slave acking at N+1). A misaligned request gives ready at N+1.
- Ack/err seen outside BUS are ignored.

Test Plan:
- 32-bit word read, addr 0x100, slave acks 1 cycle after stb with 0xDEADBEEF -> wb_sel_o = 4'b1111, wb_addr_o = 0x100, ready 2 cycles after start, data_o = 0xDEADBEEF, error = 0.
- Signed byte read, addr 0x103, wb_data_i = 0x80000000 -> sel = 4'b1000, data_o = 0xFFFFFF80. Repeated with unsigned = 1 -> 0x00000080.
- Half write 0x1234 to addr 0x202 -> wb_addr_o = 0x200, sel = 4'b1100, wb_data_o = 0x12341234, we = 1. After ack, data_o is unchanged.
- Word request at addr 0x101 -> no stb ever, ready next cycle, error = 1. clear_ready -> ready = 0. A following start is accepted.
- TIMEOUT_CYCLES = 4, slave silent -> stb high exactly 4 cycles then drops, ready with error = 3. Separately, ack and err in the same cycle -> error = 2.
- DATA_WIDTH = 64: dword read at 0x8 -> sel = 8'hFF. Reset asserted mid-BUS -> stb, cyc, ready drop immediately and data_o = 0xC0017A1EC0017A1E.

Source files
------------

// File: rtl/wb_master_bridge.sv
// Wishbone classic master bridging a load/store transaction port to the bus.
// One request at a time: IDLE accepts, BUS runs the Wishbone cycle, DONE holds
// the result until the core acknowledges it with clear_ready.
module wb_master_bridge #(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 32,
    parameter int SEL_WIDTH      = DATA_WIDTH / 8,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [ADDR_WIDTH-1:0] transaction_addr_i,
    input  logic [DATA_WIDTH-1:0] transaction_data_i,
    input  logic [1:0]            transaction_size_i,
    input  logic                  transaction_unsigned_i,
    input  logic                  transaction_we_i,
    input  logic                  transaction_start_i,
    input  logic                  transaction_clear_ready_i,
    output logic [DATA_WIDTH-1:0] transaction_data_o,
    output logic                  transaction_ready_o,
    output logic [1:0]            transaction_error_o,
    input  logic                  wb_ack_i,
    input  logic                  wb_err_i,
    input  logic [DATA_WIDTH-1:0] wb_data_i,
    output logic [ADDR_WIDTH-1:0] wb_addr_o,
    output logic [DATA_WIDTH-1:0] wb_data_o,
    output logic                  wb_we_o,
    output logic [SEL_WIDTH-1:0]  wb_sel_o,
    output logic                  wb_stb_o,
    output logic                  wb_cyc_o
);

    localparam int OFF_W = $clog2(SEL_WIDTH);
    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [DATA_WIDTH-1:0] RESET_DATA = {(DATA_WIDTH / 32){32'hC0017A1E}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [OFF_W-1:0] offset_q;
    logic [1:0]       size_q;
    logic             unsigned_q;
    logic [CNT_W-1:0] cnt;

    logic [OFF_W-1:0] req_offset;
    logic             req_illegal;
    logic             timeout_hit;
    logic             bus_exit;

    // Number of byte lanes an access of the given size covers, clamped to the bus.
    function automatic int lane_count(input logic [1:0] size);
        int n;
        n = 1 << size;
        if (n > SEL_WIDTH) n = SEL_WIDTH;
        return n;
    endfunction

    // Contiguous lane mask of the access width, shifted up to the byte offset.
    function automatic logic [SEL_WIDTH-1:0] lane_select(input logic [1:0] size,
                                                         input logic [OFF_W-1:0] off);
        logic [SEL_WIDTH-1:0] m;
        m = '0;
        for (int i = 0; i < SEL_WIDTH; i++) begin
            if (i < lane_count(size)) m[i] = 1'b1;
        end
        return m << off;
    endfunction

    // Repeat the low bytes of the write data across every lane so the slave
    // finds the right value whichever lanes are selected.
    function automatic logic [DATA_WIDTH-1:0] replicate(input logic [DATA_WIDTH-1:0] d,
                                                        input logic [1:0] size);
        logic [DATA_WIDTH-1:0] r;
        int n;
        n = lane_count(size);
        r = '0;
        for (int i = 0; i < SEL_WIDTH; i++) begin
            r[8*i +: 8] = d[8*(i % n) +: 8];
        end
        return r;
    endfunction

    // Bring the addressed bytes down to bit 0 and sign- or zero-extend them.
    function automatic logic [DATA_WIDTH-1:0] extend(input logic [DATA_WIDTH-1:0] rdata,
                                                     input logic [1:0] size,
                                                     input logic [OFF_W-1:0] off,
                                                     input logic uns);
        logic [DATA_WIDTH-1:0] sh;
        logic [DATA_WIDTH-1:0] r;
        logic sign;
        int n;
        n = lane_count(size);
        sh = rdata >> {off, 3'b000};
        sign = ~uns & sh[8*n-1];
        for (int i = 0; i < DATA_WIDTH; i++) begin
            r[i] = (i < 8*n) ? sh[i] : sign;
        end
        return r;
    endfunction

    assign req_offset = transaction_addr_i[OFF_W-1:0];

    // A request is illegal if the size exceeds the bus or the address is not naturally aligned.
    always_comb begin
        req_illegal = 1'b0;
        case (transaction_size_i)
            2'd0: req_illegal = 1'b0;
            2'd1: req_illegal = transaction_addr_i[0];
            2'd2: req_illegal = |transaction_addr_i[1:0];
            2'd3: req_illegal = (DATA_WIDTH < 64) || (|transaction_addr_i[2:0]);
            default: req_illegal = 1'b1;
        endcase
    end

    assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt == CNT_LAST);
    assign bus_exit    = wb_err_i | wb_ack_i | timeout_hit;

    // Request/bus/result state machine with all outputs registered.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state               <= IDLE;
            wb_stb_o            <= 1'b0;
            wb_cyc_o            <= 1'b0;
            wb_we_o             <= 1'b0;
            wb_sel_o            <= '0;
            wb_addr_o           <= '0;
            wb_data_o           <= '0;
            transaction_ready_o <= 1'b0;
            transaction_error_o <= 2'd0;
            transaction_data_o  <= RESET_DATA;
            cnt                 <= '0;
            offset_q            <= '0;
            size_q              <= 2'd0;
            unsigned_q          <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (transaction_start_i) begin
                        offset_q   <= req_offset;
                        size_q     <= transaction_size_i;
                        unsigned_q <= transaction_unsigned_i;
                        if (req_illegal) begin
                            state               <= DONE;
                            transaction_ready_o <= 1'b1;
                            transaction_error_o <= 2'd1;
                        end else begin
                            state               <= BUS;
                            wb_stb_o            <= 1'b1;
                            wb_cyc_o            <= 1'b1;
                            wb_we_o             <= transaction_we_i;
                            wb_sel_o            <= lane_select(transaction_size_i, req_offset);
                            wb_addr_o           <= {transaction_addr_i[ADDR_WIDTH-1:OFF_W], {OFF_W{1'b0}}};
                            wb_data_o           <= replicate(transaction_data_i, transaction_size_i);
                            transaction_error_o <= 2'd0;
                            cnt                 <= '0;
                        end
                    end
                end
                BUS: begin
                    if (bus_exit) begin
                        state               <= DONE;
                        transaction_ready_o <= 1'b1;
                        wb_stb_o            <= 1'b0;
                        wb_cyc_o            <= 1'b0;
                        wb_we_o             <= 1'b0;
                        wb_sel_o            <= '0;
                        cnt                 <= '0;
                        if (wb_err_i) begin
                            transaction_error_o <= 2'd2;
                        end else if (wb_ack_i) begin
                            transaction_error_o <= 2'd0;
                            if (!wb_we_o) begin
                                transaction_data_o <= extend(wb_data_i, size_q, offset_q, unsigned_q);
                            end
                        end else begin
                            transaction_error_o <= 2'd3;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    if (transaction_clear_ready_i) begin
                        state               <= IDLE;
                        transaction_ready_o <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_wb_master_bridge.sv
// Bench for wb_master_bridge: directed scenarios with literal expectations on a
// 32-bit instance (timeout 4) and a 64-bit instance, then randomized traffic on
// the 32-bit instance compared every cycle against a behavioural model.
module tb_wb_master_bridge;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    bit cmp_en = 1'b0;

    // 32-bit instance signals
    logic        rst;
    logic [31:0] t_addr, t_wdata;
    logic [1:0]  t_size;
    logic        t_uns, t_we, t_start, t_clr;
    logic [31:0] d_rdata;
    logic        d_ready;
    logic [1:0]  d_err;
    logic        ack, err;
    logic [31:0] wb_rd;
    logic [31:0] wb_addr, wb_wd;
    logic        wb_we, wb_stb, wb_cyc;
    logic [3:0]  wb_sel;

    // 64-bit instance signals
    logic        rst6;
    logic [31:0] a6;
    logic [63:0] wd6;
    logic [1:0]  sz6;
    logic        uns6, we6, st6, clr6;
    logic [63:0] rdata6;
    logic        ready6;
    logic [1:0]  err6;
    logic        ack6, berr6;
    logic [63:0] rd6;
    logic [31:0] addr6;
    logic [63:0] wbwd6;
    logic        wbwe6, stb6, cyc6;
    logic [7:0]  sel6;

    wb_master_bridge #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .TIMEOUT_CYCLES(4)) dut (
        .clk_i(clk), .rst_i(rst),
        .transaction_addr_i(t_addr), .transaction_data_i(t_wdata),
        .transaction_size_i(t_size), .transaction_unsigned_i(t_uns),
        .transaction_we_i(t_we), .transaction_start_i(t_start),
        .transaction_clear_ready_i(t_clr),
        .transaction_data_o(d_rdata), .transaction_ready_o(d_ready),
        .transaction_error_o(d_err),
        .wb_ack_i(ack), .wb_err_i(err), .wb_data_i(wb_rd),
        .wb_addr_o(wb_addr), .wb_data_o(wb_wd), .wb_we_o(wb_we),
        .wb_sel_o(wb_sel), .wb_stb_o(wb_stb), .wb_cyc_o(wb_cyc)
    );

    wb_master_bridge #(.DATA_WIDTH(64), .ADDR_WIDTH(32)) dut64 (
        .clk_i(clk), .rst_i(rst6),
        .transaction_addr_i(a6), .transaction_data_i(wd6),
        .transaction_size_i(sz6), .transaction_unsigned_i(uns6),
        .transaction_we_i(we6), .transaction_start_i(st6),
        .transaction_clear_ready_i(clr6),
        .transaction_data_o(rdata6), .transaction_ready_o(ready6),
        .transaction_error_o(err6),
        .wb_ack_i(ack6), .wb_err_i(berr6), .wb_data_i(rd6),
        .wb_addr_o(addr6), .wb_data_o(wbwd6), .wb_we_o(wbwe6),
        .wb_sel_o(sel6), .wb_stb_o(stb6), .wb_cyc_o(cyc6)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference arithmetic on a 32-bit bus: nb = bytes in access, off = byte offset.
    function automatic logic [3:0] f_sel(input int nb, input int off);
        return 4'(((1 << nb) - 1) << off);
    endfunction

    function automatic logic [31:0] f_rep(input logic [31:0] d, input int nb);
        logic [63:0] low, r;
        low = {32'd0, d} & ((64'd1 << (8 * nb)) - 64'd1);
        r = 64'd0;
        for (int k = 0; k < 4 / nb; k++) r = r + (low << (8 * nb * k));
        return r[31:0];
    endfunction

    function automatic logic [31:0] f_ext(input logic [31:0] w, input int nb, input int off, input logic uns);
        logic [63:0] v;
        v = ({32'd0, w} >> (8 * off)) & ((64'd1 << (8 * nb)) - 64'd1);
        if (!uns && v >= (64'd1 << (8 * nb - 1))) v = v - (64'd1 << (8 * nb));
        return v[31:0];
    endfunction

    // Behavioural model of the 32-bit instance: phase 0 idle, 1 on the bus, 2 result held.
    int          m_ph, m_cnt, m_nb, m_off;
    logic        m_stb, m_we, m_ready, m_uns;
    logic [3:0]  m_sel;
    logic [31:0] m_addr, m_wd, m_rd;
    logic [1:0]  m_err;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_ph <= 0; m_cnt <= 0; m_nb <= 1; m_off <= 0;
            m_stb <= 1'b0; m_we <= 1'b0; m_ready <= 1'b0; m_uns <= 1'b0;
            m_sel <= 4'd0; m_addr <= 32'd0; m_wd <= 32'd0;
            m_rd <= 32'hC0017A1E; m_err <= 2'd0;
        end else begin
            case (m_ph)
                0: if (t_start) begin
                    if (t_size == 2'd3 || ((t_addr % 4) % (1 << t_size)) != 0) begin
                        m_ph <= 2; m_ready <= 1'b1; m_err <= 2'd1;
                    end else begin
                        m_ph <= 1; m_stb <= 1'b1; m_we <= t_we;
                        m_sel <= f_sel(1 << t_size, int'(t_addr % 4));
                        m_addr <= t_addr - (t_addr % 4);
                        m_wd <= f_rep(t_wdata, 1 << t_size);
                        m_nb <= 1 << t_size; m_off <= int'(t_addr % 4); m_uns <= t_uns;
                        m_err <= 2'd0; m_cnt <= 0;
                    end
                end
                1: if (err || ack || m_cnt == 3) begin
                    m_ph <= 2; m_ready <= 1'b1; m_stb <= 1'b0; m_we <= 1'b0;
                    m_sel <= 4'd0; m_cnt <= 0;
                    m_err <= err ? 2'd2 : (ack ? 2'd0 : 2'd3);
                    if (!err && ack && !m_we) m_rd <= f_ext(wb_rd, m_nb, m_off, m_uns);
                end else begin
                    m_cnt <= m_cnt + 1;
                end
                default: if (t_clr) begin
                    m_ph <= 0; m_ready <= 1'b0;
                end
            endcase
        end
    end

    // Per-cycle comparison of the 32-bit instance against the model.
    initial begin
        forever begin
            @(negedge clk);
            if (cmp_en) begin
                check("stb", wb_stb, m_stb);
                check("cyc", wb_cyc, m_stb);
                check("sel", wb_sel, m_sel);
                check("we", wb_we, m_we);
                check("ready", d_ready, m_ready);
                check("error", d_err, m_err);
                check("rdata", d_rdata, m_rd);
                if (m_stb) begin
                    check("addr", wb_addr, m_addr);
                    check("wdata", wb_wd, m_wd);
                end
            end
        end
    end

    // Slave for the 32-bit instance. mode 0 random, 1 ack after sdelay, 2 silent, 3 ack+err.
    int          mode = 2;
    int          sdelay = 0;
    int          scnt = 0;
    logic [31:0] srd = 32'd0;

    initial begin
        ack = 1'b0; err = 1'b0; wb_rd = 32'd0;
        forever begin
            @(posedge clk);
            #1;
            case (mode)
                0: begin
                    ack = ($urandom_range(0, 9) < 3);
                    err = ($urandom_range(0, 9) == 0);
                    wb_rd = $urandom;
                end
                1: begin
                    if (wb_stb) begin
                        ack = (scnt == sdelay);
                        scnt++;
                    end else begin
                        ack = 1'b0;
                        scnt = 0;
                    end
                    err = 1'b0;
                    wb_rd = srd;
                end
                3: begin
                    ack = wb_stb; err = wb_stb;
                end
                default: begin
                    ack = 1'b0; err = 1'b0;
                end
            endcase
        end
    end

    int          lat, stbc;
    logic [3:0]  sel_s;
    logic [31:0] addr_s, wd_s;
    logic        we_s;

    // Issue one request on the 32-bit instance and wait (bounded) for ready.
    task automatic do_req(input logic [31:0] a, input logic [31:0] d, input logic [1:0] sz,
                          input logic u, input logic w);
        bit got;
        t_addr = a; t_wdata = d; t_size = sz; t_uns = u; t_we = w; t_start = 1'b1;
        lat = 0; stbc = 0; sel_s = 4'd0; addr_s = 32'd0; wd_s = 32'd0; we_s = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(posedge clk);
            #1;
            t_start = 1'b0;
            lat++;
            if (wb_stb) begin
                if (stbc == 0) begin
                    sel_s = wb_sel; addr_s = wb_addr; wd_s = wb_wd; we_s = wb_we;
                end
                stbc++;
            end
            if (d_ready) got = 1'b1;
        end
        if (!got) check("ready_wait", d_ready, 1'b1);
    endtask

    task automatic clear_ready();
        t_clr = 1'b1;
        @(posedge clk);
        #1;
        t_clr = 1'b0;
        check("clear_ready", d_ready, 1'b0);
    endtask

    initial begin
        rst = 1'b1; rst6 = 1'b1;
        t_addr = 0; t_wdata = 0; t_size = 0; t_uns = 0; t_we = 0; t_start = 0; t_clr = 0;
        a6 = 0; wd6 = 0; sz6 = 0; uns6 = 0; we6 = 0; st6 = 0; clr6 = 0;
        ack6 = 0; berr6 = 0; rd6 = 0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_data", d_rdata, 32'hC0017A1E);
        check("rst_ready", d_ready, 1'b0);
        check("rst_error", d_err, 2'd0);
        check("rst_stb", wb_stb, 1'b0);
        check("rst_sel", wb_sel, 4'd0);
        check("rst_data64", rdata6, 64'hC0017A1EC0017A1E);
        check("pin_rep", f_rep(32'h000000AB, 1), 32'hABABABAB);
        check("pin_ext", f_ext(32'h80000000, 1, 3, 1'b0), 32'hFFFFFF80);
        rst = 1'b0; rst6 = 1'b0;
        cmp_en = 1'b1;
        @(posedge clk);
        #1;

        // Word read, zero-wait slave
        mode = 1; sdelay = 0; srd = 32'hDEADBEEF;
        do_req(32'h100, 32'h0, 2'd2, 1'b0, 1'b0);
        check("t1_sel", sel_s, 4'hF);
        check("t1_addr", addr_s, 32'h100);
        check("t1_latency", lat, 2);
        check("t1_data", d_rdata, 32'hDEADBEEF);
        check("t1_error", d_err, 2'd0);
        clear_ready();

        // Signed and unsigned byte reads from the top lane
        srd = 32'h80000000; sdelay = 1;
        do_req(32'h103, 32'h0, 2'd0, 1'b0, 1'b0);
        check("t2_sel", sel_s, 4'b1000);
        check("t2_sdata", d_rdata, 32'hFFFFFF80);
        clear_ready();
        do_req(32'h103, 32'h0, 2'd0, 1'b1, 1'b0);
        check("t2_udata", d_rdata, 32'h00000080);
        clear_ready();

        // Half write, upper input bytes must not leak onto the bus
        srd = 32'h55555555; sdelay = 0;
        do_req(32'h202, 32'hFFFF1234, 2'd1, 1'b0, 1'b1);
        check("t3_addr", addr_s, 32'h200);
        check("t3_sel", sel_s, 4'b1100);
        check("t3_wdata", wd_s, 32'h12341234);
        check("t3_we", we_s, 1'b1);
        check("t3_data_kept", d_rdata, 32'h00000080);
        clear_ready();

        // Misaligned word: no bus cycle, error 1, then a normal request is accepted
        do_req(32'h101, 32'h0, 2'd2, 1'b0, 1'b0);
        check("t4_stb_count", stbc, 0);
        check("t4_latency", lat, 1);
        check("t4_error", d_err, 2'd1);
        clear_ready();
        check("t4_error_held", d_err, 2'd1);
        srd = 32'h13572468;
        do_req(32'h104, 32'h0, 2'd2, 1'b0, 1'b0);
        check("t4_next_latency", lat, 2);
        check("t4_next_data", d_rdata, 32'h13572468);
        check("t4_next_error", d_err, 2'd0);
        clear_ready();

        // Silent slave times out after four strobe cycles
        mode = 2;
        do_req(32'h0, 32'h0, 2'd2, 1'b0, 1'b0);
        check("t5_stb_count", stbc, 4);
        check("t5_error", d_err, 2'd3);
        check("t5_data_kept", d_rdata, 32'h13572468);
        clear_ready();

        // Simultaneous ack and err: err wins
        mode = 3;
        do_req(32'h10, 32'h0, 2'd2, 1'b0, 1'b0);
        check("t6_error", d_err, 2'd2);
        check("t6_data_kept", d_rdata, 32'h13572468);
        clear_ready();
        mode = 2;

        // 64-bit instance: dword read
        a6 = 32'h8; sz6 = 2'd3; we6 = 1'b0; uns6 = 1'b0; st6 = 1'b1;
        @(posedge clk); #1; st6 = 1'b0;
        check("d64_stb", stb6, 1'b1);
        check("d64_sel", sel6, 8'hFF);
        check("d64_addr", addr6, 32'h8);
        ack6 = 1'b1; rd6 = 64'h0123456789ABCDEF;
        @(posedge clk); #1; ack6 = 1'b0;
        check("d64_ready", ready6, 1'b1);
        check("d64_stb_drop", stb6, 1'b0);
        check("d64_data", rdata6, 64'h0123456789ABCDEF);
        check("d64_error", err6, 2'd0);
        clr6 = 1'b1; @(posedge clk); #1; clr6 = 1'b0;
        check("d64_clear", ready6, 1'b0);

        // 64-bit instance: signed word from the upper half
        a6 = 32'h4; sz6 = 2'd2; st6 = 1'b1;
        @(posedge clk); #1; st6 = 1'b0;
        check("w64_sel", sel6, 8'hF0);
        check("w64_addr", addr6, 32'h0);
        ack6 = 1'b1; rd6 = 64'h80000000_00000000;
        @(posedge clk); #1; ack6 = 1'b0;
        check("w64_data", rdata6, 64'hFFFFFFFF80000000);
        clr6 = 1'b1; @(posedge clk); #1; clr6 = 1'b0;

        // 64-bit instance: reset in the middle of a bus cycle
        a6 = 32'h8; sz6 = 2'd3; st6 = 1'b1;
        @(posedge clk); #1; st6 = 1'b0;
        check("r64_stb_before", stb6, 1'b1);
        @(posedge clk); #1;
        rst6 = 1'b1;
        #1;
        check("r64_stb", stb6, 1'b0);
        check("r64_cyc", cyc6, 1'b0);
        check("r64_sel", sel6, 8'h00);
        check("r64_ready", ready6, 1'b0);
        check("r64_data", rdata6, 64'hC0017A1EC0017A1E);
        @(posedge clk); #1;
        rst6 = 1'b0;

        // Randomized traffic on the 32-bit instance, with one asynchronous reset
        mode = 0;
        for (int n = 0; n < 3000; n++) begin
            t_start = ($urandom_range(0, 1) == 1);
            t_clr   = ($urandom_range(0, 2) == 0);
            t_addr  = $urandom;
            t_wdata = $urandom;
            t_size  = 2'($urandom_range(0, 3));
            t_uns   = ($urandom_range(0, 1) == 1);
            t_we    = ($urandom_range(0, 1) == 1);
            if (n == 1500) rst = 1'b1;
            if (n == 1502) rst = 1'b0;
            @(posedge clk);
            #1;
        end
        t_start = 1'b0; t_clr = 1'b0;
        @(posedge clk); #1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
